// File: rtl/weighted_filter_pipe.sv
// Edge-preserving weighted mean over a WIN x WIN window: weights, products, sums,
// then a bit-serial restoring divide. One window in flight, valid/ready on both sides.
module weighted_filter_pipe #(
  parameter int PIX_W = 8,
  parameter int WIN   = 3,
  parameter int W_MAX = 248
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIN*WIN*PIX_W-1:0] win_pixels,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PIX_W-1:0]         out_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int N   = WIN * WIN;
  localparam int C   = (N - 1) / 2;
  localparam int DW  = PIX_W + 1;
  localparam int PW2 = 2 * PIX_W;
  localparam int AW  = 2 * PIX_W + 5;
  localparam int BW  = PIX_W + 5;
  localparam int CW  = $clog2(PIX_W + 1);
  localparam logic [PIX_W:0] WMAX_L = DW'(W_MAX);

  typedef enum logic [2:0] {IDLE, WEIGHT, SUM, DIV, OUT} state_t;
  state_t state, state_nxt;

  logic [N*PIX_W-1:0] win_p0;
  logic [1:0]         mode_p0;
  logic [PIX_W-1:0]   w_p1    [N];
  logic [PW2-1:0]     prod_p1 [N];
  logic [AW-1:0]      a_p2;
  logic [BW-1:0]      b_p2;
  logic [BW-1:0]      rem_p3;
  logic [PIX_W-1:0]   num_p3;
  logic [PIX_W-2:0]   quot_p3;
  logic [CW-1:0]      cnt;

  logic [PIX_W-1:0] w_nxt    [N];
  logic [PW2-1:0]   prod_nxt [N];
  logic [AW-1:0]    a_sum;
  logic [BW-1:0]    b_sum;
  logic [BW:0]      rem_sh;
  logic [BW-1:0]    rem_sub;
  logic [BW-1:0]    rem_nxt;
  logic             q_bit;
  logic             accept;

  // Mode 01 is a plain box mean, 10 passes the centre through, 00/11 are adaptive.
  function automatic logic [PIX_W-1:0] tap_weight(input logic [PIX_W-1:0] p,
                                                  input logic [PIX_W-1:0] pc,
                                                  input logic [1:0]       m,
                                                  input logic             is_c);
    logic signed [PIX_W+1:0] diff;
    logic [PIX_W:0]          d;
    logic [PIX_W-1:0]        w;
    diff = $signed({2'b00, p}) - $signed({2'b00, pc});
    d    = diff[PIX_W+1] ? DW'(-diff) : DW'(diff);
    w    = (d >= WMAX_L) ? '0 : PIX_W'(WMAX_L - d);
    case (m)
      2'b01:   tap_weight = PIX_W'(1);
      2'b10:   tap_weight = is_c ? PIX_W'(1) : '0;
      default: tap_weight = is_c ? PIX_W'(W_MAX) : w;
    endcase
  endfunction

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WEIGHT;
      WEIGHT:  state_nxt = SUM;
      SUM:     state_nxt = DIV;
      DIV:     if (cnt == CW'(PIX_W)) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = in_valid ? WEIGHT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_nxt[i]    = tap_weight(win_p0[i*PIX_W +: PIX_W], win_p0[C*PIX_W +: PIX_W],
                               mode_p0, (i == C));
      prod_nxt[i] = PW2'(w_nxt[i]) * PW2'(win_p0[i*PIX_W +: PIX_W]);
    end
  end

  always_comb begin
    a_sum = '0;
    b_sum = '0;
    for (int i = 0; i < N; i++) begin
      a_sum = a_sum + AW'(prod_p1[i]);
      b_sum = b_sum + BW'(w_p1[i]);
    end
  end

  // Partial remainder always stays below B, so only the shifted value needs the extra bit.
  always_comb begin
    rem_sh  = {rem_p3, num_p3[PIX_W-1]};
    q_bit   = (rem_sh >= {1'b0, b_p2});
    rem_sub = rem_sh[BW-1:0] - b_p2;
    rem_nxt = q_bit ? rem_sub : rem_sh[BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_p0    <= '0;
      mode_p0   <= '0;
      for (int i = 0; i < N; i++) begin
        w_p1[i]    <= '0;
        prod_p1[i] <= '0;
      end
      a_p2      <= '0;
      b_p2      <= '0;
      rem_p3    <= '0;
      num_p3    <= '0;
      quot_p3   <= '0;
      cnt       <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
    end else begin
      // p0: capture the window on the accept edge
      if (accept) begin
        win_p0  <= win_pixels;
        mode_p0 <= mode;
      end
      // p1: per-tap weights and products
      if (state == WEIGHT) begin
        for (int i = 0; i < N; i++) begin
          w_p1[i]    <= w_nxt[i];
          prod_p1[i] <= prod_nxt[i];
        end
      end
      // p2: numerator and denominator sums
      if (state == SUM) begin
        a_p2 <= a_sum;
        b_p2 <= b_sum;
        cnt  <= '0;
      end
      // p3: first DIV cycle loads the divider, then one quotient bit per cycle
      if (state == DIV) begin
        cnt <= cnt + CW'(1);
        if (cnt == '0) begin
          rem_p3  <= a_p2[AW-1:PIX_W];
          num_p3  <= a_p2[PIX_W-1:0];
          quot_p3 <= '0;
        end else begin
          rem_p3  <= rem_nxt;
          num_p3  <= {num_p3[PIX_W-2:0], 1'b0};
          quot_p3 <= {quot_p3[PIX_W-3:0], q_bit};
          if (cnt == CW'(PIX_W)) begin
            out_pixel <= {quot_p3, q_bit};
            out_valid <= 1'b1;
          end
        end
      end
      if ((state == OUT) && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_weighted_filter_pipe.sv
// Directed and randomized checks of weighted_filter_pipe at PIX_W=8, WIN=3, W_MAX=248.
module tb_weighted_filter_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] win_pixels = '0;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weighted_filter_pipe #(.PIX_W(8), .WIN(3), .W_MAX(248)) dut (
    .clk(clk), .rst(rst), .win_pixels(win_pixels), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  function automatic logic [71:0] make_win(input int c, input int n);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = (i == 4) ? 8'(c) : 8'(n);
    return w;
  endfunction

  function automatic int model(input logic [71:0] w, input logic [1:0] m);
    int a, b, pc, p, d, wt;
    a = 0;
    b = 0;
    pc = int'(w[32 +: 8]);
    for (int i = 0; i < 9; i++) begin
      p = int'(w[i*8 +: 8]);
      d = (p > pc) ? p - pc : pc - p;
      if (m == 2'b01)      wt = 1;
      else if (m == 2'b10) wt = (i == 4) ? 1 : 0;
      else if (i == 4)     wt = 248;
      else                 wt = (d >= 248) ? 0 : 248 - d;
      a += wt * p;
      b += wt;
    end
    return a / b;
  endfunction

  task automatic send(input logic [71:0] w, input logic [1:0] m, output bit ok);
    int g;
    g = 0;
    ok = 1'b0;
    win_pixels = w;
    mode = m;
    in_valid = 1'b1;
    while (!ok && g < 100) begin
      ok = in_ready;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    win_pixels = ~w;
    mode = ~m;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_pixel !== 8'd0) begin failures++; $display("FAIL reset_out_pixel: got %0d expected 0", out_pixel); end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_adaptive();
    int cs [6] = '{100, 0,   100, 0,   0,   50};
    int ns [6] = '{100, 255, 110, 247, 248, 50};
    int ms [6] = '{0,   0,   0,   3,   0,   3};
    int es [6] = '{100, 0,   108, 7,   0,   50};
    int lat;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      send(make_win(cs[k], ns[k]), 2'(ms[k]), ok);
      wait_out(lat);
      checks++; if (lat != 11) begin failures++; $display("FAIL adaptive_latency[%0d]: got %0d expected 11", k, lat); end
      checks++; if (out_pixel !== 8'(es[k])) begin failures++; $display("FAIL adaptive_value[%0d]: got %0d expected %0d", k, out_pixel, es[k]); end
      pop();
    end
  endtask

  task automatic test_box_bypass();
    logic [71:0] w;
    int lat;
    bit ok;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'((i + 1) * 10);
    send(w, 2'b01, ok);
    wait_out(lat);
    checks++; if (out_pixel !== 8'd50) begin failures++; $display("FAIL box_ramp: got %0d expected 50", out_pixel); end
    pop();
    send(make_win(77, 0), 2'b10, ok);
    wait_out(lat);
    checks++; if (out_pixel !== 8'd77) begin failures++; $display("FAIL bypass_zero_nbr: got %0d expected 77", out_pixel); end
    pop();
    send(make_win(77, 200), 2'b10, ok);
    wait_out(lat);
    checks++; if (out_pixel !== 8'd77) begin failures++; $display("FAIL bypass_high_nbr: got %0d expected 77", out_pixel); end
    pop();
  endtask

  task automatic test_backpressure();
    logic [71:0] w;
    int lat;
    int bad;
    bit ok;
    send(make_win(100, 100), 2'b00, ok);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_pixel !== 8'd100 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'((i + 1) * 10);
    win_pixels = w;
    mode = 2'b01;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL out_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    win_pixels = '0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_out(lat);
    checks++; if (lat != 11) begin failures++; $display("FAIL b2b_latency: got %0d expected 11", lat); end
    checks++; if (out_pixel !== 8'd50) begin failures++; $display("FAIL b2b_value: got %0d expected 50", out_pixel); end
    pop();
  endtask

  task automatic test_reset_during_div();
    int seen;
    bit ok;
    send(make_win(100, 110), 2'b00, ok);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL div_reset_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div_reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL div_reset_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL div_reset_discard: got %0d active cycles expected 0", seen); end
    checks++; if (out_pixel !== 8'd0) begin failures++; $display("FAIL div_reset_pixel: got %0d expected 0", out_pixel); end
  endtask

  task automatic test_random_stream();
    int exp_q[$];
    int got;
    got = 0;
    fork
      begin
        logic [71:0] w;
        logic [1:0]  m;
        int base, p, g;
        bit acc;
        for (int k = 0; k < 20; k++) begin
          base = int'($urandom_range(0, 255));
          for (int i = 0; i < 9; i++) begin
            p = base + int'($urandom_range(0, 80)) - 40;
            if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 255));
            if (p < 0) p = 0;
            if (p > 255) p = 255;
            w[i*8 +: 8] = 8'(p);
          end
          m = 2'($urandom_range(0, 3));
          win_pixels = w;
          mode = m;
          in_valid = 1'b1;
          acc = 1'b0;
          g = 0;
          while (!acc && g < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            g++;
          end
          if (acc) exp_q.push_back(model(w, m));
        end
        in_valid = 1'b0;
      end
      begin
        int cyc, e;
        cyc = 0;
        while (got < 20 && cyc < 3000) begin
          @(posedge clk); #2;
          out_ready = $urandom_range(0, 1) == 1;
          @(negedge clk);
          if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL stream_extra: got %0d expected no output", out_pixel);
            end else begin
              e = exp_q.pop_front();
              if (out_pixel !== 8'(e)) begin
                failures++;
                $display("FAIL stream_value[%0d]: got %0d expected %0d", got, out_pixel, e);
              end
            end
            got++;
          end
          cyc++;
        end
        @(posedge clk); #2;
        out_ready = 1'b0;
      end
    join
    checks++; if (got != 20) begin failures++; $display("FAIL stream_count: got %0d expected 20", got); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_adaptive();
    test_box_bypass();
    test_backpressure();
    test_reset_during_div();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
